// File: rtl/cdce_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : cdce_spi_responder
// Purpose  : SPI responder for the CDCE62002-style 32-bit LSB-first register
//            protocol. Oversamples SCLK/CS/MOSI on sysclk, decodes write,
//            read-command and EEPROM-command frames, and holds two 28-bit
//            configuration registers plus a read-only status readback.
// Options  : CDCE_SPI_READBACK_EN - when defined, enables the read command
//            (address 0xE) and MISO readback; when undefined MISO is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module cdce_spi_responder #(
    parameter logic [27:0] REG0_RESET = 28'h0000000,
    parameter logic [27:0] REG1_RESET = 28'h0000000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_cs_INV,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [27:0] status,
    output logic [27:0] reg0,
    output logic [27:0] reg1,
    output logic [1:0]  wr_strobe,
    output logic        eeprom_cmd,
    output logic        frame_err
);

    localparam logic [5:0] c_FRAME_BITS  = 6'd32;
    localparam logic [5:0] c_CNT_SAT     = 6'd33;
    localparam logic [3:0] c_ADDR_REG0   = 4'h0;
    localparam logic [3:0] c_ADDR_REG1   = 4'h1;
    localparam logic [3:0] c_ADDR_EEPROM = 4'hF;
    localparam logic [1:0] c_SETTLED     = 2'd2;

    // ------------------------------------------------------------------
    // Synchronisers: equal depth on all three inputs keeps MOSI aligned
    // with SCLK; the extra stage on SCLK and CS is for edge detection.
    // ------------------------------------------------------------------
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_cs_s1,   r_cs_s2,   r_cs_s3;
    logic r_mosi_s1, r_mosi_s2;

    // Input synchroniser chains (CS stages reset to deasserted)
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_s3   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_clk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_cs_s1   <= spi_cs_INV;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;

    // ------------------------------------------------------------------
    // Arming: the reset values of the CS stages would otherwise turn a CS
    // that is already low at reset release into a fake falling edge. A
    // frame may only start once CS has been genuinely seen high.
    // ------------------------------------------------------------------
    logic [1:0] r_settle;
    logic       r_armed;

    // Wait for the synchroniser to hold real input, then for CS high
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != c_SETTLED) begin
                r_settle <= r_settle + 2'd1;
            end
            if ((r_settle == c_SETTLED) && r_cs_s2) begin
                r_armed <= 1'b1;
            end
        end
    end

    logic w_frame_start;
    logic w_sclk_rise_act;

    assign w_frame_start   = w_cs_fall & r_armed;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic        r_in_frame;
    logic        r_end_pend;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_rx;

    // CS high in the synced domain dominates a coincident SCLK edge
    assign w_sclk_rise_act = w_sclk_rise & ~r_cs_s2 & r_in_frame;

    // Frame tracking, LSB-first shift-in and saturating bit counter
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_in_frame <= 1'b0;
            r_end_pend <= 1'b0;
            r_bit_cnt  <= 6'd0;
            r_rx       <= 32'd0;
        end else begin
            r_end_pend <= 1'b0;
            if (w_frame_start) begin
                r_in_frame <= 1'b1;
                r_bit_cnt  <= 6'd0;
            end else if (w_cs_rise) begin
                r_in_frame <= 1'b0;
                r_end_pend <= r_in_frame;
            end else if (w_sclk_rise_act) begin
                r_rx <= {r_mosi_s2, r_rx[31:1]};
                if (r_bit_cnt != c_CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame decode (one cycle after the synced CS rise so that commit
    // lands three sysclk edges after CS is first sampled high)
    // ------------------------------------------------------------------
    logic [3:0]  w_addr;
    logic [27:0] w_data;
    logic        w_len_ok;
    logic        w_commit;
    logic        w_bad_len;
    logic        w_wr0;
    logic        w_wr1;
    logic        w_eep;

    // Split the captured word and classify the frame
    always_comb begin
        w_addr    = r_rx[3:0];
        w_data    = r_rx[31:4];
        w_len_ok  = (r_bit_cnt == c_FRAME_BITS);
        w_commit  = r_end_pend & w_len_ok;
        w_bad_len = r_end_pend & ~w_len_ok;
        w_wr0     = w_commit & (w_addr == c_ADDR_REG0);
        w_wr1     = w_commit & (w_addr == c_ADDR_REG1);
        w_eep     = w_commit & (w_addr == c_ADDR_EEPROM);
    end

    logic [27:0] r_reg0;
    logic [27:0] r_reg1;
    logic [1:0]  r_wr_strobe;
    logic        r_eeprom_cmd;
    logic        r_frame_err;

    // Register file update and single-cycle event pulses
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_reg0       <= REG0_RESET;
            r_reg1       <= REG1_RESET;
            r_wr_strobe  <= 2'b00;
            r_eeprom_cmd <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wr_strobe  <= {w_wr1, w_wr0};
            r_eeprom_cmd <= w_eep;
            r_frame_err  <= w_bad_len;
            if (w_wr0) begin
                r_reg0 <= w_data;
            end
            if (w_wr1) begin
                r_reg1 <= w_data;
            end
        end
    end

    assign reg0       = r_reg0;
    assign reg1       = r_reg1;
    assign wr_strobe  = r_wr_strobe;
    assign eeprom_cmd = r_eeprom_cmd;
    assign frame_err  = r_frame_err;

`ifdef CDCE_SPI_READBACK_EN
    // ------------------------------------------------------------------
    // Readback path
    // ------------------------------------------------------------------
    localparam logic [3:0] c_ADDR_RDCMD = 4'hE;

    logic        w_sclk_fall_act;
    logic        w_rdcmd;
    logic [27:0] w_rd_value;
    logic [31:0] r_tx;
    logic        r_rd_pending;
    logic [3:0]  r_rd_addr;
    logic        r_miso;

    assign w_sclk_fall_act = ~r_sclk_s2 & r_sclk_s3 & ~r_cs_s2 & r_in_frame;
    assign w_rdcmd         = w_commit & (w_addr == c_ADDR_RDCMD);

    // Select the readback source for the pending read address
    always_comb begin
        w_rd_value = 28'h0000000;
        case (r_rd_addr)
            4'd0:    w_rd_value = r_reg0;
            4'd1:    w_rd_value = r_reg1;
            4'd2:    w_rd_value = status;
            default: w_rd_value = 28'h0000000;
        endcase
    end

    // Read-command latch and transmit shifter (loaded at frame start)
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_tx         <= 32'd0;
            r_rd_pending <= 1'b0;
            r_rd_addr    <= 4'd0;
        end else begin
            if (w_frame_start) begin
                r_tx         <= r_rd_pending ? {w_rd_value, r_rd_addr} : 32'd0;
                r_rd_pending <= 1'b0;
            end else begin
                if (w_sclk_fall_act) begin
                    r_tx <= {1'b0, r_tx[31:1]};
                end
                if (w_rdcmd) begin
                    r_rd_pending <= 1'b1;
                    r_rd_addr    <= w_data[3:0];
                end
            end
        end
    end

    // MISO output register, forced low outside an active frame
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_miso <= 1'b0;
        end else begin
            r_miso <= r_tx[0] & ~r_cs_s2 & r_in_frame;
        end
    end

    assign spi_miso = r_miso;
`else
    // Readback removed: address 0xE falls through as an ignored address
    logic w_unused_status;
    assign w_unused_status = ^status;
    assign spi_miso        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdce_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdce_spi_responder
// Purpose  : Directed self-checking bench for cdce_spi_responder: writes,
//            readback, status read, bad-length frames, EEPROM command and
//            reset in mid-frame. MISO expectations follow CDCE_SPI_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdce_spi_responder;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        spi_clk;
    logic        spi_cs_INV;
    logic        spi_mosi;
    logic        spi_miso;
    logic [27:0] status;
    logic [27:0] reg0;
    logic [27:0] reg1;
    logic [1:0]  wr_strobe;
    logic        eeprom_cmd;
    logic        frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_err_pulses = 0;
    int n_eep_pulses = 0;
    int n_wr_pulses  = 0;

    logic [63:0] miso_word;

    cdce_spi_responder dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .spi_clk    (spi_clk),
        .spi_cs_INV (spi_cs_INV),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .status     (status),
        .reg0       (reg0),
        .reg1       (reg1),
        .wr_strobe  (wr_strobe),
        .eeprom_cmd (eeprom_cmd),
        .frame_err  (frame_err)
    );

    always #5 sysclk = ~sysclk;

    // Pulse tallies for "exactly once" checks
    always @(posedge sysclk) begin
        if (frame_err)        n_err_pulses++;
        if (eeprom_cmd)       n_eep_pulses++;
        if (wr_strobe != 2'b00) n_wr_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        @(negedge sysclk);
        spi_cs_INV = 1'b0;
    endtask

    // Shift n bits LSB first; sample MISO just before each SCLK rise
    task automatic send_bits(input logic [63:0] bits, input int n, output logic [63:0] mw);
        mw = 64'd0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = bits[i];
            repeat (4) @(negedge sysclk);
            mw[i] = spi_miso;
            spi_clk = 1'b1;
            repeat (4) @(negedge sysclk);
            spi_clk = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    // Raise CS and check the commit pulses land exactly 3 edges later
    task automatic cs_high_check(input string tag, input logic [1:0] exp_wr,
                                 input logic exp_eep, input logic exp_err);
        repeat (2) @(negedge sysclk);
        spi_cs_INV = 1'b1;
        repeat (3) @(negedge sysclk);
        chk({tag, "_pre"}, {wr_strobe, eeprom_cmd, frame_err}, 4'b0000);
        @(negedge sysclk);
        chk({tag, "_pulse"}, {wr_strobe, eeprom_cmd, frame_err}, {exp_wr, exp_eep, exp_err});
        @(negedge sysclk);
        chk({tag, "_post"}, {wr_strobe, eeprom_cmd, frame_err}, 4'b0000);
        chk({tag, "_miso_idle"}, spi_miso, 1'b0);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic frame(input string tag, input logic [63:0] bits, input int n,
                         input logic [1:0] exp_wr, input logic exp_eep, input logic exp_err,
                         output logic [63:0] mw);
        cs_low();
        send_bits(bits, n, mw);
        cs_high_check(tag, exp_wr, exp_eep, exp_err);
    endtask

    function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef CDCE_SPI_READBACK_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        reset      = 1'b1;
        spi_clk    = 1'b0;
        spi_cs_INV = 1'b1;
        spi_mosi   = 1'b0;
        status     = 28'h0000000;
        repeat (3) @(negedge sysclk);
        chk("rst_reg0", reg0, 28'h0);
        chk("rst_reg1", reg1, 28'h0);
        chk("rst_pulses", {wr_strobe, eeprom_cmd, frame_err}, 4'b0000);
        chk("rst_miso", spi_miso, 1'b0);
        reset = 1'b0;
        repeat (6) @(negedge sysclk);

        // Write reg0
        frame("wr0", {32'h0, 28'h1234567, 4'h0}, 32, 2'b01, 1'b0, 1'b0, miso_word);
        chk("wr0_reg0", reg0, 28'h1234567);
        chk("wr0_reg1", reg1, 28'h0);
        chk("wr0_miso", miso_word[31:0], 32'h0);

        // Write reg1, read command for reg1, then readback frame, then empty
        frame("wr1", {32'h0, 28'hABCDEF0, 4'h1}, 32, 2'b10, 1'b0, 1'b0, miso_word);
        chk("wr1_reg1", reg1, 28'hABCDEF0);
        frame("rdcmd1", {32'h0, 28'h0000001, 4'hE}, 32, 2'b00, 1'b0, 1'b0, miso_word);
        chk("rdcmd1_miso", miso_word[31:0], 32'h0);
        frame("rb1", {32'h0, 28'h0000000, 4'h5}, 32, 2'b00, 1'b0, 1'b0, miso_word);
        chk("rb1_miso", miso_word[31:0], rb(32'hABCDEF01));
        frame("rb1_after", {32'h0, 28'h0000000, 4'h5}, 32, 2'b00, 1'b0, 1'b0, miso_word);
        chk("rb1_after_miso", miso_word[31:0], 32'h0);

        // Status read
        status = 28'h5A5A5A5;
        frame("rdcmd2", {32'h0, 28'h0000002, 4'hE}, 32, 2'b00, 1'b0, 1'b0, miso_word);
        frame("rb2", {32'h0, 28'h0000000, 4'h5}, 32, 2'b00, 1'b0, 1'b0, miso_word);
        chk("rb2_miso", miso_word[31:0], rb(32'h5A5A5A52));

        // Short and long frames
        frame("short", {32'h0, 28'hFFFFFFF, 4'h0}, 31, 2'b00, 1'b0, 1'b1, miso_word);
        chk("short_reg0", reg0, 28'h1234567);
        frame("long", {31'h0, 1'b1, 28'hFFFFFFF, 4'h0}, 33, 2'b00, 1'b0, 1'b1, miso_word);
        chk("long_reg0", reg0, 28'h1234567);

        // EEPROM command
        frame("eeprom", {32'h0, 28'h0000000, 4'hF}, 32, 2'b00, 1'b1, 1'b0, miso_word);
        chk("eeprom_reg0", reg0, 28'h1234567);
        chk("eeprom_reg1", reg1, 28'hABCDEF0);

        // Reset after 16 bits; the tail of that frame must be ignored
        cs_low();
        send_bits({32'h0, 28'h7654321, 4'h0}, 16, miso_word);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        chk("midrst_reg0", reg0, 28'h0);
        chk("midrst_reg1", reg1, 28'h0);
        chk("midrst_pulses", {wr_strobe, eeprom_cmd, frame_err}, 4'b0000);
        chk("midrst_miso", spi_miso, 1'b0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        send_bits({48'h0, 16'h7654}, 16, miso_word);
        cs_high_check("stale", 2'b00, 1'b0, 1'b0);
        chk("stale_reg0", reg0, 28'h0);

        frame("wr_post", {32'h0, 28'h7654321, 4'h1}, 32, 2'b10, 1'b0, 1'b0, miso_word);
        chk("wr_post_reg1", reg1, 28'h7654321);
        chk("wr_post_reg0", reg0, 28'h0);

        chk("tally_err", n_err_pulses, 2);
        chk("tally_eep", n_eep_pulses, 1);
        chk("tally_wr", n_wr_pulses, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
